// File: rtl/fe_ctrl_pkg.sv
// Shared types and constants for the Qu front-end sequencer.
package fe_ctrl_pkg;

    localparam int QU_PC_WIDTH     = 32;
    localparam int FE_BOOT_CYCLES  = 4;
    localparam int FE_FLUSH_CYCLES = 2;

    // Encoding 2'd3 is reserved and never accepted.
    typedef enum logic [1:0] {
        RD_BR  = 2'd0,
        RD_JMP = 2'd1,
        RD_EXC = 2'd2
    } redirect_type_t;

    typedef enum logic [2:0] {
        FE_BOOT     = 3'd0,
        FE_RUN      = 3'd1,
        FE_REDIRECT = 3'd2,
        FE_FLUSH    = 3'd3,
        FE_DRAIN    = 3'd4,
        FE_HALT     = 3'd5
    } fe_state_t;

    // True for the three defined redirect encodings.
    function automatic logic redirect_type_legal(input logic [1:0] rtype);
        return (rtype != 2'd3);
    endfunction

endpackage

// File: rtl/fe_ctrl.sv
// Front-end sequencer: boot hold-off, redirect/flush sequencing,
// back-pressure stalls and drain-to-halt for the fetch..rename pipeline.
module fe_ctrl
    import fe_ctrl_pkg::*;
#(
    parameter int PC_WIDTH     = QU_PC_WIDTH,
    parameter int BOOT_CYCLES  = FE_BOOT_CYCLES,
    parameter int FLUSH_CYCLES = FE_FLUSH_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [1:0]          redirect_type,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                redirect_ready,
    input  logic                halt_req,
    output logic                halted,
    input  logic                rob_full,
    input  logic                res_st_full,
    input  logic                map_full,
    input  logic                imem_wait,
    input  logic                fifo_if_id_empty,
    input  logic                fifo_id_mp_empty,
    input  logic                fifo_mp_rn_empty,
    output logic                if_en,
    output logic                id_en,
    output logic                stall,
    output logic                if_stall,
    output logic                id_stall,
    output logic                mp_stall,
    output logic                rn_stall,
    output logic                branch,
    output logic                jump,
    output logic                exception,
    output logic [PC_WIDTH-1:0] pc_override,
    output logic                flush
);

    localparam int CNT_MAX   = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    fe_state_t            state_r;
    fe_state_t            state_nx_s;
    fe_state_t            out_state_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nx_s;
    redirect_type_t       lat_type_r;
    logic [PC_WIDTH-1:0]  lat_pc_r;
    logic                 ready_s;
    logic                 accept_s;
    logic                 drained_s;
    logic                 bp_rn_s;
    logic                 bp_mp_s;

    assign accept_s  = redirect_valid && ready_s;
    assign drained_s = fifo_if_id_empty && fifo_id_mp_empty && fifo_mp_rn_empty;
    assign bp_rn_s   = rob_full || res_st_full;
    assign bp_mp_s   = bp_rn_s || map_full;

    // Reset forces BOOT outputs immediately so no pulse leaks into the reset cycle.
    always_comb begin
        if (!rst) begin
            out_state_s = FE_BOOT;
        end else begin
            out_state_s = state_r;
        end
    end

    // Redirect acceptance: open in RUN/DRAIN; only an exception may pre-empt a non-exception recovery.
    always_comb begin
        ready_s = 1'b0;
        case (out_state_s)
            FE_RUN, FE_DRAIN:     ready_s = redirect_type_legal(redirect_type);
            FE_REDIRECT, FE_FLUSH: ready_s = (redirect_type == RD_EXC) && (lat_type_r != RD_EXC);
            default:              ready_s = 1'b0;
        endcase
    end

    // State, shared boot/flush counter and redirect latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= FE_BOOT;
            cnt_r      <= '0;
            lat_type_r <= RD_BR;
            lat_pc_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (accept_s) begin
                lat_type_r <= redirect_type_t'(redirect_type);
                lat_pc_r   <= redirect_pc;
            end else begin
                lat_type_r <= lat_type_r;
                lat_pc_r   <= lat_pc_r;
            end
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            FE_BOOT: begin
                if (cnt_r == CNT_WIDTH'(BOOT_CYCLES - 1)) begin
                    state_nx_s = FE_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_WIDTH'(1);
                end
            end
            FE_RUN: begin
                if (accept_s) begin
                    state_nx_s = FE_REDIRECT;
                    cnt_nx_s   = '0;
                end else if (halt_req) begin
                    state_nx_s = FE_DRAIN;
                end else begin
                    state_nx_s = FE_RUN;
                end
            end
            FE_REDIRECT: begin
                cnt_nx_s = '0;
                if (accept_s) begin
                    state_nx_s = FE_REDIRECT;
                end else begin
                    state_nx_s = FE_FLUSH;
                end
            end
            FE_FLUSH: begin
                if (accept_s) begin
                    state_nx_s = FE_REDIRECT;
                    cnt_nx_s   = '0;
                end else if (cnt_r == CNT_WIDTH'(FLUSH_CYCLES - 1)) begin
                    state_nx_s = FE_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_WIDTH'(1);
                end
            end
            FE_DRAIN: begin
                if (accept_s) begin
                    state_nx_s = FE_REDIRECT;
                    cnt_nx_s   = '0;
                end else if (!halt_req) begin
                    state_nx_s = FE_RUN;
                end else if (drained_s) begin
                    state_nx_s = FE_HALT;
                end else begin
                    state_nx_s = FE_DRAIN;
                end
            end
            FE_HALT: begin
                if (!halt_req) begin
                    state_nx_s = FE_RUN;
                end else begin
                    state_nx_s = FE_HALT;
                end
            end
            default: begin
                state_nx_s = FE_BOOT;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Moore output decode; only RUN/DRAIN stage stalls follow the back-pressure inputs.
    always_comb begin
        if_en          = 1'b0;
        id_en          = 1'b0;
        stall          = 1'b1;
        if_stall       = 1'b1;
        id_stall       = 1'b1;
        mp_stall       = 1'b1;
        rn_stall       = 1'b1;
        branch         = 1'b0;
        jump           = 1'b0;
        exception      = 1'b0;
        pc_override    = '0;
        flush          = 1'b1;
        halted         = 1'b0;
        redirect_ready = ready_s;
        case (out_state_s)
            FE_RUN, FE_DRAIN: begin
                if_en    = (out_state_s == FE_RUN);
                id_en    = 1'b1;
                stall    = 1'b0;
                flush    = 1'b0;
                if_stall = imem_wait;
                rn_stall = bp_rn_s;
                mp_stall = bp_mp_s;
                id_stall = bp_mp_s;
            end
            FE_REDIRECT: begin
                branch      = (lat_type_r == RD_BR);
                jump        = (lat_type_r == RD_JMP);
                exception   = (lat_type_r == RD_EXC);
                pc_override = lat_pc_r;
            end
            FE_HALT: begin
                halted = 1'b1;
                flush  = 1'b0;
            end
            FE_FLUSH: begin
                flush = 1'b1;
            end
            default: begin
                flush = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fe_ctrl.sv
// Self-checking bench for fe_ctrl: directed sequences, a back-pressure
// vector table, and randomized traffic checked against a cycle model.
module tb_fe_ctrl;

    localparam int BOOT  = 4;
    localparam int FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [1:0]  redirect_type;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        halt_req;
    logic        halted;
    logic        rob_full, res_st_full, map_full, imem_wait;
    logic        fifo_if_id_empty, fifo_id_mp_empty, fifo_mp_rn_empty;
    logic        if_en, id_en, stall, if_stall, id_stall, mp_stall, rn_stall;
    logic        branch, jump, exception, flush;
    logic [31:0] pc_override;

    int checks = 0;
    int errors = 0;

    fe_ctrl #(.PC_WIDTH(32), .BOOT_CYCLES(BOOT), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_type(redirect_type),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .halt_req(halt_req), .halted(halted),
        .rob_full(rob_full), .res_st_full(res_st_full), .map_full(map_full),
        .imem_wait(imem_wait),
        .fifo_if_id_empty(fifo_if_id_empty), .fifo_id_mp_empty(fifo_id_mp_empty),
        .fifo_mp_rn_empty(fifo_mp_rn_empty),
        .if_en(if_en), .id_en(id_en), .stall(stall),
        .if_stall(if_stall), .id_stall(id_stall), .mp_stall(mp_stall), .rn_stall(rn_stall),
        .branch(branch), .jump(jump), .exception(exception),
        .pc_override(pc_override), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model: remaining boot cycles, remaining recovery cycles,
    // the pending redirect, and drain/halt mode flags.
    int          m_boot   = BOOT;
    int          m_recov  = 0;
    logic        m_drain  = 1'b0;
    logic        m_halted = 1'b0;
    logic [1:0]  m_kind   = 2'd0;
    logic [31:0] m_pc     = 32'd0;

    // Vector order: if_en id_en stall if_stall id_stall mp_stall rn_stall branch jump exception flush ready halted
    task automatic model_expect(output logic [12:0] v, output logic [31:0] pc);
        logic in_boot, recov, pulse, bp_rn, bp_mp;
        logic ie, de, st, is, ds, ms, rs, br, jp, ex, fl, rd, hl;
        in_boot = !rst || (m_boot > 0);
        recov   = !in_boot && (m_recov > 0);
        pulse   = recov && (m_recov == FLUSH + 1);
        bp_rn   = rob_full | res_st_full;
        bp_mp   = bp_rn | map_full;
        ie = 1'b0; de = 1'b0; st = 1'b1; is = 1'b1; ds = 1'b1; ms = 1'b1; rs = 1'b1;
        br = 1'b0; jp = 1'b0; ex = 1'b0; fl = 1'b1; rd = 1'b0; hl = 1'b0; pc = 32'd0;
        if (in_boot) begin
            fl = 1'b1;
        end else if (recov) begin
            rd = (redirect_type == 2'd2) && (m_kind != 2'd2);
            br = pulse && (m_kind == 2'd0);
            jp = pulse && (m_kind == 2'd1);
            ex = pulse && (m_kind == 2'd2);
            pc = pulse ? m_pc : 32'd0;
        end else if (m_halted) begin
            fl = 1'b0;
            hl = 1'b1;
        end else begin
            st = 1'b0; fl = 1'b0;
            is = imem_wait; ds = bp_mp; ms = bp_mp; rs = bp_rn;
            de = 1'b1; ie = !m_drain;
            rd = (redirect_type != 2'd3);
        end
        v = {ie, de, st, is, ds, ms, rs, br, jp, ex, fl, rd, hl};
    endtask

    // Advance the model on each clock edge using the inputs the DUT sees.
    always @(posedge clk) begin
        logic [12:0] v;
        logic [31:0] pc;
        logic        acc;
        if (!rst) begin
            m_boot = BOOT; m_recov = 0; m_drain = 1'b0; m_halted = 1'b0;
            m_kind = 2'd0; m_pc = 32'd0;
        end else begin
            model_expect(v, pc);
            acc = redirect_valid && v[1];
            if (m_boot > 0) begin
                m_boot = m_boot - 1;
            end else if (acc) begin
                m_recov = FLUSH + 1; m_kind = redirect_type; m_pc = redirect_pc; m_drain = 1'b0;
            end else if (m_recov > 0) begin
                m_recov = m_recov - 1;
            end else if (m_halted) begin
                if (!halt_req) m_halted = 1'b0;
            end else if (m_drain) begin
                if (!halt_req) m_drain = 1'b0;
                else if (fifo_if_id_empty && fifo_id_mp_empty && fifo_mp_rn_empty) begin
                    m_drain = 1'b0; m_halted = 1'b1;
                end
            end else if (halt_req) begin
                m_drain = 1'b1;
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        logic [12:0] ev, av;
        logic [31:0] epc;
        model_expect(ev, epc);
        av = {if_en, id_en, stall, if_stall, id_stall, mp_stall, rn_stall,
              branch, jump, exception, flush, redirect_ready, halted};
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL model_outputs t=%0t actual=%b required=%b", $time, av, ev);
        end
        checks++;
        if (pc_override !== epc) begin
            errors++;
            $display("FAIL model_pc t=%0t actual=%h required=%h", $time, pc_override, epc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic redir(input logic [1:0] t, input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_type = t; redirect_pc = pc;
    endtask

    typedef struct {
        logic [3:0] bp_in;   // rob_full res_st_full map_full imem_wait
        logic [3:0] exp_st;  // if_stall id_stall mp_stall rn_stall
    } bp_vec_t;

    bp_vec_t bp_tab [7];

    initial begin
        bp_tab[0] = '{4'b0000, 4'b0000};
        bp_tab[1] = '{4'b1000, 4'b0111};
        bp_tab[2] = '{4'b0100, 4'b0111};
        bp_tab[3] = '{4'b0010, 4'b0110};
        bp_tab[4] = '{4'b0001, 4'b1000};
        bp_tab[5] = '{4'b1111, 4'b1111};
        bp_tab[6] = '{4'b0011, 4'b1110};

        rst = 1'b0; redirect_valid = 1'b0; redirect_type = 2'd0; redirect_pc = 32'd0;
        halt_req = 1'b0; rob_full = 1'b0; res_st_full = 1'b0; map_full = 1'b0; imem_wait = 1'b0;
        fifo_if_id_empty = 1'b1; fifo_id_mp_empty = 1'b1; fifo_mp_rn_empty = 1'b1;

        // Reset held for three edges, then four stalled boot cycles.
        next();
        smp();
        chk("rst_flush", {31'd0, flush}, 32'd1);
        chk("rst_ready", {31'd0, redirect_ready}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        next(); next();
        rst = 1'b1;
        for (int i = 0; i < BOOT; i++) begin
            smp();
            chk("boot_stall", {31'd0, stall}, 32'd1);
            chk("boot_if_en", {31'd0, if_en}, 32'd0);
            next();
        end
        smp();
        chk("run_stall", {31'd0, stall}, 32'd0);
        chk("run_if_en", {31'd0, if_en}, 32'd1);
        chk("run_ready", {31'd0, redirect_ready}, 32'd1);

        // Branch redirect.
        next(); redir(2'd0, 32'h0000_0100);
        smp(); chk("br_ready", {31'd0, redirect_ready}, 32'd1);
        next(); redirect_valid = 1'b0;
        smp();
        chk("br_pulse", {29'd0, branch, jump, exception}, 32'd4);
        chk("br_pc", pc_override, 32'h100);
        chk("br_flush1", {31'd0, flush}, 32'd1);
        next(); smp();
        chk("br_flush2", {31'd0, flush}, 32'd1);
        chk("br_pulse_gone", {31'd0, branch}, 32'd0);
        next(); smp(); chk("br_flush3", {31'd0, flush}, 32'd1);
        next(); smp();
        chk("br_run_stall", {31'd0, stall}, 32'd0);
        chk("br_run_flush", {31'd0, flush}, 32'd0);

        // Exception pre-empts a jump recovery.
        next(); redir(2'd1, 32'h200);
        next(); redirect_valid = 1'b0;
        next(); redir(2'd2, 32'h80);
        smp(); chk("pe_ready", {31'd0, redirect_ready}, 32'd1);
        next(); redirect_valid = 1'b0;
        smp();
        chk("pe_pulse", {29'd0, branch, jump, exception}, 32'd1);
        chk("pe_pc", pc_override, 32'h80);
        next(); next(); smp(); chk("pe_flush_t5", {31'd0, flush}, 32'd1);
        next(); smp(); chk("pe_run", {31'd0, stall}, 32'd0);

        // Branch cannot pre-empt a jump recovery.
        next(); redir(2'd1, 32'h200);
        next(); redirect_valid = 1'b0;
        next(); redir(2'd0, 32'h300);
        smp(); chk("pe_br_ready", {31'd0, redirect_ready}, 32'd0);
        next(); redirect_valid = 1'b0;
        smp(); chk("pe_br_nopulse", {29'd0, branch, jump, exception}, 32'd0);
        next(); smp(); chk("pe_br_run", {31'd0, stall}, 32'd0);

        // Back-pressure vectors in RUN.
        for (int i = 0; i < 7; i++) begin
            next();
            {rob_full, res_st_full, map_full, imem_wait} = bp_tab[i].bp_in;
            smp();
            chk("bp_stalls", {28'd0, if_stall, id_stall, mp_stall, rn_stall}, {28'd0, bp_tab[i].exp_st});
        end
        next();
        {rob_full, res_st_full, map_full, imem_wait} = 4'b0000;

        // Drain with non-empty FIFOs, then halt, then resume.
        fifo_if_id_empty = 1'b0; fifo_id_mp_empty = 1'b0; fifo_mp_rn_empty = 1'b0; halt_req = 1'b1;
        smp(); chk("h_run_if_en", {31'd0, if_en}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            next(); smp();
            chk("h_drain_en", {30'd0, if_en, id_en}, 32'd1);
            chk("h_drain_halted", {31'd0, halted}, 32'd0);
        end
        next();
        fifo_if_id_empty = 1'b1; fifo_id_mp_empty = 1'b1; fifo_mp_rn_empty = 1'b1;
        smp(); chk("h_drain_last", {31'd0, halted}, 32'd0);
        next(); smp();
        chk("h_halted", {31'd0, halted}, 32'd1);
        chk("h_halt_stall", {31'd0, stall}, 32'd1);
        chk("h_halt_flush", {31'd0, flush}, 32'd0);
        chk("h_halt_ready", {31'd0, redirect_ready}, 32'd0);
        next(); halt_req = 1'b0;
        smp(); chk("h_halt_hold", {31'd0, halted}, 32'd1);
        next(); smp();
        chk("h_resume_halted", {31'd0, halted}, 32'd0);
        chk("h_resume_if_en", {31'd0, if_en}, 32'd1);

        // Illegal redirect type is never accepted.
        for (int i = 0; i < 4; i++) begin
            next(); redir(2'd3, 32'hdead_0000);
            smp();
            chk("ill_ready", {31'd0, redirect_ready}, 32'd0);
            chk("ill_flush", {31'd0, flush}, 32'd0);
        end
        next(); redirect_valid = 1'b0; redirect_type = 2'd0;
        smp(); chk("ill_run", {31'd0, stall}, 32'd0);

        // Reset during FLUSH.
        next(); redir(2'd0, 32'h40);
        next(); redirect_valid = 1'b0;
        next(); rst = 1'b0;
        smp();
        chk("rf_pulse", {29'd0, branch, jump, exception}, 32'd0);
        chk("rf_flush", {31'd0, flush}, 32'd1);
        next(); rst = 1'b1;
        smp(); chk("rf_boot", {30'd0, stall, if_en}, 32'd2);
        repeat (BOOT) next();
        smp(); chk("rf_run", {31'd0, stall}, 32'd0);

        // Reset during REDIRECT suppresses the pulse in that same cycle.
        next(); redir(2'd1, 32'h44);
        next(); redirect_valid = 1'b0; rst = 1'b0;
        smp();
        chk("rr_jump", {31'd0, jump}, 32'd0);
        chk("rr_pc", pc_override, 32'd0);
        next(); rst = 1'b1;
        repeat (BOOT) next();
        smp(); chk("rr_run", {31'd0, stall}, 32'd0);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            next();
            rst              = ($urandom_range(0, 199) != 0);
            redirect_valid   = ($urandom_range(0, 4) == 0);
            redirect_type    = 2'($urandom_range(0, 3));
            redirect_pc      = $urandom;
            if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
            rob_full         = ($urandom_range(0, 3) == 0);
            res_st_full      = ($urandom_range(0, 3) == 0);
            map_full         = ($urandom_range(0, 3) == 0);
            imem_wait        = ($urandom_range(0, 3) == 0);
            fifo_if_id_empty = ($urandom_range(0, 9) < 7);
            fifo_id_mp_empty = ($urandom_range(0, 9) < 7);
            fifo_mp_rn_empty = ($urandom_range(0, 9) < 7);
        end
        next();
        smp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
